// File: rtl/glycemic_pkg.sv
// Shared types and constants for the blood sensor link and the glycemic
// index calculator. The receiver FSM state encoding lives here so that
// the monitor controller can decode it for debug.
package glycemic_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam int   SENSOR_DATA_BITS  = 8;
  localparam logic SENSOR_IDLE_LEVEL = 1'b1;
  localparam int   GI_WIDTH          = 4;

  // Even parity over a sensor payload: the parity bit that makes the total
  // number of ones even.
  function automatic logic even_parity(input logic [SENSOR_DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/bit_timer.sv
// Bit-period timer for the sensor receiver. A load arms the down-counter
// with a half or full bit period; tick pulses for exactly one cycle when an
// armed count reaches zero. A load in the tick cycle re-arms seamlessly.
module bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic load_half,
  input  logic load_full,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] ZERO      = {CW{1'b0}};
  localparam logic [CW-1:0] ONE       = CW'(1);

  logic [CW-1:0] count_q, count_d;
  logic          armed_q, armed_d;

  // Tick only once per load; an unarmed timer sitting at zero stays silent.
  assign tick = armed_q && (count_q == ZERO);

  // Next count: loads take priority, otherwise count down while armed.
  always_comb begin
    count_d = count_q;
    armed_d = armed_q;
    if (load_full) begin
      count_d = FULL_LOAD;
      armed_d = 1'b1;
    end else if (load_half) begin
      count_d = HALF_LOAD;
      armed_d = 1'b1;
    end else if (armed_q && (count_q == ZERO)) begin
      armed_d = 1'b0;
    end else if (armed_q) begin
      count_d = count_q - ONE;
    end else begin
      count_d = count_q;
    end
  end

  // Counter state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= ZERO;
      armed_q <= 1'b0;
    end else begin
      count_q <= count_d;
      armed_q <= armed_d;
    end
  end

endmodule

// File: rtl/blood_sensor_rx.sv
// Serial receiver for the blood sensor 1-wire frame:
//   start(0), 8 data bits MSB first, [even parity], stop(1).
// Holds the last good sample behind a valid/ready handshake and reports
// framing, parity and overrun faults.
// Build option: define BLOOD_SENSOR_PARITY_EN to expect a parity bit.
module blood_sensor_rx
  import glycemic_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sensorLine,
  output logic [7:0] bloodSensor,
  output logic       sampleValid,
  input  logic       sampleReady,
  output logic       busy,
  output logic       frameError,
  output logic       parityError,
  output logic       overrun
);

  localparam int DATA_BITS = SENSOR_DATA_BITS;
  localparam int BW        = $clog2(DATA_BITS);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] BIT_ZERO = {BW{1'b0}};
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);

  logic sync1_q, sync2_q, prev_q;
  logic rx_s, fall_s, tick_s, load_half_s, load_full_s, good_s;

  rx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                 par_bad_q, par_bad_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
`ifdef BLOOD_SENSOR_PARITY_EN
  logic                 par_err_q, par_err_d;
`endif

  assign rx_s   = sync2_q;
  assign fall_s = (prev_q == SENSOR_IDLE_LEVEL) && (sync2_q != SENSOR_IDLE_LEVEL);

  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
    .clk       (clk),
    .rst       (reset),
    .load_half (load_half_s),
    .load_full (load_full_s),
    .tick      (tick_s)
  );

  // Two-flop synchroniser plus one history flop for start-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= SENSOR_IDLE_LEVEL;
      sync2_q <= SENSOR_IDLE_LEVEL;
      prev_q  <= SENSOR_IDLE_LEVEL;
    end else begin
      sync1_q <= sensorLine;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Frame FSM: next state, bit timing loads, shift register and fault flags.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    par_bad_d   = par_bad_q;
    load_half_s = 1'b0;
    load_full_s = 1'b0;
    frame_err_d = 1'b0;
    good_s      = 1'b0;
`ifdef BLOOD_SENSOR_PARITY_EN
    par_err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (fall_s) begin
          state_d     = START;
          load_half_s = 1'b1;
          bit_cnt_d   = BIT_LAST;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (!tick_s) begin
          state_d = START;
        end else if (rx_s == SENSOR_IDLE_LEVEL) begin
          state_d = IDLE;          // glitch, not a real start bit
        end else begin
          state_d     = DATA;
          load_full_s = 1'b1;
          bit_cnt_d   = BIT_LAST;
          par_bad_d   = 1'b0;
        end
      end
      DATA: begin
        if (tick_s) begin
          shift_d     = {shift_q[DATA_BITS-2:0], rx_s};
          load_full_s = 1'b1;
          if (bit_cnt_q == BIT_ZERO) begin
            bit_cnt_d = BIT_LAST;
`ifdef BLOOD_SENSOR_PARITY_EN
            state_d   = PARITY;
`else
            state_d   = STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q - BIT_ONE;
          end
        end else begin
          state_d = DATA;
        end
      end
`ifdef BLOOD_SENSOR_PARITY_EN
      PARITY: begin
        if (tick_s) begin
          state_d     = STOP;
          load_full_s = 1'b1;
          bit_cnt_d   = BIT_LAST;
          if (rx_s != even_parity(shift_q)) begin
            par_bad_d = 1'b1;
            par_err_d = 1'b1;
          end else begin
            par_bad_d = 1'b0;
          end
        end else begin
          state_d = PARITY;
        end
      end
`endif
      STOP: begin
        if (tick_s) begin
          state_d   = IDLE;
          bit_cnt_d = BIT_LAST;
          if (rx_s != SENSOR_IDLE_LEVEL) begin
            frame_err_d = 1'b1;
          end else if (!par_bad_q) begin
            good_s = 1'b1;
          end else begin
            good_s = 1'b0;
          end
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output side: sample holding register, handshake and sticky overrun.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    busy_d    = (state_d != IDLE);
    if (good_s) begin
      data_d  = shift_q;
      valid_d = 1'b1;
      if (valid_q && !sampleReady) begin
        overrun_d = 1'b1;
      end else begin
        overrun_d = overrun_q;
      end
    end else if (valid_q && sampleReady) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State and output registers; reset aborts any frame in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      shift_q     <= {DATA_BITS{1'b0}};
      bit_cnt_q   <= BIT_ZERO;
      par_bad_q   <= 1'b0;
      data_q      <= {DATA_BITS{1'b0}};
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      par_bad_q   <= par_bad_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef BLOOD_SENSOR_PARITY_EN
  // Parity fault pulse register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= par_err_d;
    end
  end
  assign parityError = par_err_q;
`else
  assign parityError = 1'b0;
`endif

  assign bloodSensor = data_q;
  assign sampleValid = valid_q;
  assign busy        = busy_q;
  assign frameError  = frame_err_q;
  assign overrun     = overrun_q;

endmodule
